// File: rtl/gals_pkg.sv
// gals_pkg: state encoding and timing defaults shared by the GALS step issuer and collector
package gals_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_REQ    = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } gals_state_e;

    localparam int GALS_WATCHDOG_TIMEOUT = 10000;
    localparam int GALS_INTER_STEP_GAP   = 4;

endpackage

// File: rtl/gals_wdog_counter.sv
// gals_wdog_counter: clearable up-counter that saturates at LIMIT and flags the terminal count
module gals_wdog_counter #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic local_clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [W-1:0] count;

    assign tc = count == W'(LIMIT);

    always_ff @(posedge local_clk) begin
        if (!rst_n || clr)
            count <= '0;
        else if (en && !tc)
            count <= count + W'(1);
    end
endmodule

// File: rtl/gals_step_issuer.sv
// gals_step_issuer: per-timestep PE launch and AER request/acknowledge initiator with watchdog
module gals_step_issuer
    import gals_pkg::*;
#(
    parameter int MAX_STEPS        = 256,
    parameter int WATCHDOG_TIMEOUT = GALS_WATCHDOG_TIMEOUT,
    parameter int INTER_STEP_GAP   = GALS_INTER_STEP_GAP
) (
    input  logic                           local_clk,
    input  logic                           rst_n,
    input  logic                           i_start,
    input  logic [$clog2(MAX_STEPS+1)-1:0] i_num_steps,
    input  logic                           i_clear,
    output logic                           o_aer_req,
    input  logic                           i_aer_ack,
    input  logic                           i_collector_error,
    output logic                           o_pe_start,
    output logic [$clog2(MAX_STEPS+1)-1:0] o_step_idx,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_error
);
    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam int WW = $clog2(WATCHDOG_TIMEOUT) + 1;
    localparam int GW = $clog2(INTER_STEP_GAP + 1) + 1;
    localparam int GL = INTER_STEP_GAP > 0 ? INTER_STEP_GAP - 1 : 0;

    gals_state_e   state;
    logic [SW-1:0] step_cnt;
    logic [SW-1:0] run_len;
    logic [SW-1:0] step_next;
    logic [SW-1:0] num_clamped;
    logic          wd_tc;
    logic          gap_tc;

    assign step_next   = step_cnt + SW'(1);
    assign num_clamped = i_num_steps > SW'(MAX_STEPS) ? SW'(MAX_STEPS) : i_num_steps;

    // Watchdog restarts every time the block is outside S_REQ
    gals_wdog_counter #(.W(WW), .LIMIT(WATCHDOG_TIMEOUT)) u_wdog (
        .local_clk (local_clk),
        .rst_n     (rst_n),
        .clr       (state != S_REQ),
        .en        (state == S_REQ),
        .tc        (wd_tc)
    );

    // Terminal count at GAP-1 so S_GAP lasts exactly INTER_STEP_GAP cycles
    gals_wdog_counter #(.W(GW), .LIMIT(GL)) u_gap (
        .local_clk (local_clk),
        .rst_n     (rst_n),
        .clr       (state != S_GAP),
        .en        (state == S_GAP),
        .tc        (gap_tc)
    );

    always_ff @(posedge local_clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            step_cnt <= '0;
            run_len  <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    run_len  <= num_clamped;
                    step_cnt <= '0;
                    state    <= i_num_steps == '0 ? S_DONE : S_LAUNCH;
                end
                S_LAUNCH: state <= i_collector_error ? S_ERROR : S_REQ;
                // Errors win over a coincident acknowledge so the step is not counted
                S_REQ: if (i_collector_error || wd_tc) begin
                    state <= S_ERROR;
                end else if (i_aer_ack) begin
                    step_cnt <= step_next;
                    state    <= step_next == run_len ? S_DONE : INTER_STEP_GAP == 0 ? S_LAUNCH : S_GAP;
                end
                S_GAP:  state <= i_collector_error ? S_ERROR : gap_tc ? S_LAUNCH : S_GAP;
                S_DONE: state <= S_IDLE;
                S_ERROR: if (i_clear) begin
                    state    <= S_IDLE;
                    step_cnt <= '0;
                    run_len  <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_aer_req  = state == S_REQ;
    assign o_pe_start = state == S_LAUNCH;
    assign o_busy     = state != S_IDLE;
    assign o_done     = state == S_DONE;
    assign o_error    = state == S_ERROR;
    assign o_step_idx = step_cnt;
endmodule

// File: tb/tb_gals_step_issuer.sv
// tb_gals_step_issuer: two issuers (gap 4 and gap 0) driven by a reactive collector model,
// with expected launch/done/error events scoreboarded against an event-timeline model.
module tb_gals_step_issuer;
    localparam int MAXS  = 8;
    localparam int TMO   = 20;
    localparam int GAP0  = 4;
    localparam int EV_PE = 0, EV_DONE = 1, EV_ERR = 2;

    typedef struct packed {
        logic [1:0] kind;
        int         cyc;
        int         idx;
    } ev_t;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       start = 0;
    logic [3:0] num = '0;
    logic       clear = 0;
    logic       ack[2], cerr[2], req[2], pe[2], busy[2], done[2], err[2];
    logic [3:0] idx[2];

    int  cyc = 0, checks = 0, errors = 0;
    ev_t q[2][$];
    int  m_len[2], m_steps[2], m_idle_from[2];
    bit  m_err[2];
    int  dmin = 1, dmax = 1;
    bit  silent = 0, inject = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        gals_step_issuer #(
            .MAX_STEPS(MAXS), .WATCHDOG_TIMEOUT(TMO), .INTER_STEP_GAP(g == 0 ? GAP0 : 0)
        ) u_dut (
            .local_clk(clk), .rst_n(rst_n), .i_start(start), .i_num_steps(num), .i_clear(clear),
            .o_aer_req(req[g]), .i_aer_ack(ack[g]), .i_collector_error(cerr[g]),
            .o_pe_start(pe[g]), .o_step_idx(idx[g]), .o_busy(busy[g]), .o_done(done[g]),
            .o_error(err[g])
        );
    end

    function automatic int gap_of(int g);
        return g == 0 ? GAP0 : 0;
    endfunction

    task automatic push(int g, int kind, int c, int i);
        ev_t e;
        e.kind = 2'(kind);
        e.cyc  = c;
        e.idx  = i;
        q[g].push_back(e);
    endtask

    task automatic expect_eq(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ev(int g, int kind, int c);
        ev_t e;
        if (q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected event: got kind %0d expected none (cycle %0d)", g, kind, c);
            return;
        end
        e = q[g].pop_front();
        expect_eq($sformatf("dut%0d event kind", g), kind, int'(e.kind));
        expect_eq($sformatf("dut%0d event cycle kind %0d", g, kind), c, e.cyc);
        if (e.idx >= 0) expect_eq($sformatf("dut%0d step_idx at kind %0d", g, kind), int'(idx[g]), e.idx);
    endtask

    // Monitor: compares DUT events to the scoreboard and checks the handshake rule
    initial begin
        bit p_ack[2], p_err[2], p_done[2];
        for (int g = 0; g < 2; g++) begin
            p_ack[g] = 0;
            p_err[g] = 0;
            p_done[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (p_ack[g]) expect_eq($sformatf("dut%0d req after ack", g), int'(req[g]), 0);
                if (p_done[g]) expect_eq($sformatf("dut%0d busy after done", g), int'(busy[g]), 0);
                if (pe[g]) check_ev(g, EV_PE, cyc);
                if (done[g]) check_ev(g, EV_DONE, cyc);
                if (err[g] && !p_err[g]) begin
                    check_ev(g, EV_ERR, cyc);
                    expect_eq($sformatf("dut%0d req in error", g), int'(req[g]), 0);
                end
                p_ack[g]  = ack[g];
                p_err[g]  = err[g];
                p_done[g] = done[g];
            end
        end
    end

    // Collector model: acknowledges each request after a random delay and predicts the outcome
    initial begin
        int rcnt[2], dly[2];
        for (int g = 0; g < 2; g++) begin
            ack[g] = 0;
            cerr[g] = 0;
            rcnt[g] = 0;
            dly[g] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                ack[g]  = 0;
                cerr[g] = 0;
                if (!req[g]) begin
                    rcnt[g] = 0;
                end else begin
                    if (rcnt[g] == 0) begin
                        dly[g] = $urandom_range(dmax, dmin);
                        if (silent) begin
                            push(g, EV_ERR, cyc + TMO + 1, m_steps[g]);
                            m_err[g] = 1;
                        end
                    end
                    if (!silent && rcnt[g] == dly[g]) begin
                        ack[g] = 1;
                        if (inject && m_steps[g] == 1) begin
                            cerr[g] = 1;
                            push(g, EV_ERR, cyc + 1, 1);
                            m_err[g] = 1;
                        end else begin
                            m_steps[g]++;
                            if (m_steps[g] == m_len[g]) begin
                                push(g, EV_DONE, cyc + 1, m_len[g]);
                                m_idle_from[g] = cyc + 2;
                            end else begin
                                push(g, EV_PE, cyc + 1 + gap_of(g), m_steps[g]);
                            end
                        end
                    end
                    rcnt[g]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        start = 1;
        num   = 4'(n);
        for (int g = 0; g < 2; g++) begin
            if (!m_err[g] && m_idle_from[g] <= cyc) begin
                m_len[g]   = n > MAXS ? MAXS : n;
                m_steps[g] = 0;
                if (n == 0) begin
                    push(g, EV_DONE, cyc + 1, -1);
                    m_idle_from[g] = cyc + 2;
                end else begin
                    push(g, EV_PE, cyc + 1, 0);
                    m_idle_from[g] = 32'h7fff_ffff;
                end
            end
        end
        tick();
        start = 0;
    endtask

    task automatic settle(string name);
        int k = 0;
        while (!(q[0].size() == 0 && q[1].size() == 0 && (!busy[0] || err[0]) && (!busy[1] || err[1]))
               && k < 3000) begin
            tick();
            k++;
        end
        expect_eq({name, " settles"}, int'(k < 3000), 1);
    endtask

    task automatic do_clear();
        clear = 1;
        for (int g = 0; g < 2; g++) begin
            if (m_err[g]) begin
                m_err[g] = 0;
                m_idle_from[g] = cyc + 1;
            end
        end
        tick();
        clear = 0;
        tick();
        for (int g = 0; g < 2; g++) begin
            expect_eq($sformatf("dut%0d busy after clear", g), int'(busy[g]), 0);
            expect_eq($sformatf("dut%0d error after clear", g), int'(err[g]), 0);
        end
    endtask

    task automatic check_zero(string tag);
        for (int g = 0; g < 2; g++) begin
            expect_eq($sformatf("%s dut%0d req", tag, g), int'(req[g]), 0);
            expect_eq($sformatf("%s dut%0d pe_start", tag, g), int'(pe[g]), 0);
            expect_eq($sformatf("%s dut%0d done", tag, g), int'(done[g]), 0);
            expect_eq($sformatf("%s dut%0d error", tag, g), int'(err[g]), 0);
            expect_eq($sformatf("%s dut%0d busy", tag, g), int'(busy[g]), 0);
            expect_eq($sformatf("%s dut%0d step_idx", tag, g), int'(idx[g]), 0);
        end
    endtask

    initial begin
        int k;
        for (int g = 0; g < 2; g++) begin
            m_len[g] = 0;
            m_steps[g] = 0;
            m_idle_from[g] = 0;
            m_err[g] = 0;
        end
        rst_n = 0;
        tick();
        tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        rst_n = 1;
        tick();
        dmin = 5; dmax = 5;
        run(3);
        settle("nominal");
        dmin = 1; dmax = 1;
        run(4);
        settle("back-to-back");
        for (int r = 0; r < 6; r++) begin
            dmin = 0; dmax = 8;
            run($urandom_range(MAXS, 1));
            settle("random");
            tick();
        end
        run(0);
        settle("zero steps");
        dmin = 0; dmax = 3;
        run(MAXS + 5);
        settle("clamp");
        silent = 1;
        run(3);
        settle("timeout");
        silent = 0;
        run(2);
        repeat (5) tick();
        for (int g = 0; g < 2; g++) begin
            expect_eq($sformatf("dut%0d error held after start", g), int'(err[g]), 1);
            expect_eq($sformatf("dut%0d busy held after start", g), int'(busy[g]), 1);
        end
        do_clear();
        inject = 1; dmin = 0; dmax = 4;
        run(4);
        settle("collector error");
        inject = 0;
        do_clear();
        dmin = 2; dmax = 2;
        run(5);
        k = 0;
        while (!(idx[0] == 4'd2 && !req[0] && !pe[0] && busy[0]) && k < 500) begin
            tick();
            k++;
        end
        expect_eq("reach step 2 gap", int'(k < 500), 1);
        rst_n = 0;
        tick();
        for (int g = 0; g < 2; g++) begin
            q[g].delete();
            m_err[g] = 0;
            m_steps[g] = 0;
            m_idle_from[g] = 0;
        end
        rst_n = 1;
        @(negedge clk);
        check_zero("mid-run reset");
        tick();
        dmin = 0; dmax = 5;
        run(3);
        settle("post-reset run");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
